// File: rtl/cpu_pkg.sv
// Shared definitions for the memory-side blocks: address width, access-size
// encodings, arbiter state encoding and the access-size decoder.
package cpu_pkg;

  localparam int ADDR_W = 17;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_IC_RD  = 2'd1,
    ARB_LSB_RD = 2'd2,
    ARB_LSB_WR = 2'd3
  } arb_state_t;

  // Encoding 11 is not a legal size and is handled as a word.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      SZ_W:    n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer for one RAM access: counter, wrapping address, stall hold,
// write-data byte select and read-byte capture.
module mem_byte_seq #(
  parameter int MAX_BYTES = 4,
  parameter int ADDR_W    = 17,
  parameter int CNT_W     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base,
  input  logic [CNT_W-1:0]       nbytes,
  input  logic                   run,
  input  logic                   wr,
  input  logic                   stall,
  input  logic [31:0]            wdata,
  input  logic [7:0]             mem_din,
  output logic [ADDR_W-1:0]      mem_a,
  output logic [7:0]             mem_dout,
  output logic                   mem_wr,
  output logic                   last,
  output logic [8*MAX_BYTES-1:0] cap_data
);

  logic [ADDR_W-1:0]      base_r;
  logic [CNT_W-1:0]       n_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [8*MAX_BYTES-1:0] buf_r;
  logic [8*MAX_BYTES-1:0] buf_nx_s;
  logic                   issue_s;
  logic                   cap_s;

  // Address/data drive and capture of the byte returned for the previous address.
  always_comb begin
    issue_s  = run && (cnt_r < n_r);
    cap_s    = run && !wr && (cnt_r != '0);
    buf_nx_s = buf_r;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (cap_s && (cnt_r == CNT_W'(i + 1))) begin
        buf_nx_s[8*i +: 8] = mem_din;
      end else begin
        buf_nx_s[8*i +: 8] = buf_r[8*i +: 8];
      end
    end
    if (issue_s) begin
      mem_a = base_r + ADDR_W'(cnt_r);
    end else begin
      mem_a = '0;
    end
    if (issue_s && wr) begin
      mem_dout = wdata[{cnt_r[1:0], 3'b000} +: 8];
    end else begin
      mem_dout = 8'h00;
    end
    mem_wr = issue_s && wr && !stall;
    // Writes finish on the last accepted byte; reads one cycle later on its capture.
    if (wr) begin
      last = issue_s && !stall && (cnt_r == (n_r - CNT_W'(1)));
    end else begin
      last = run && (cnt_r == n_r);
    end
    cap_data = buf_nx_s;
  end

  // Access parameters are latched at grant; the counter holds while a write stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      base_r <= '0;
      n_r    <= '0;
      cnt_r  <= '0;
      buf_r  <= '0;
    end else if (start) begin
      base_r <= base;
      n_r    <= nbytes;
      cnt_r  <= '0;
      buf_r  <= '0;
    end else if (run) begin
      if (!wr || !stall) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      buf_r <= buf_nx_s;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache refill and the load/store buffer,
// with round-robin grant, flush abort of reads and registered done pulses.
module mem_arbiter #(
  parameter int LINE_BYTES = 4,
  parameter int ADDR_W     = cpu_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    wr_stall,
  input  logic                    ic_req,
  input  logic [ADDR_W-1:0]       ic_addr,
  output logic                    ic_done,
  output logic [8*LINE_BYTES-1:0] ic_data,
  input  logic                    lsb_req,
  input  logic                    lsb_we,
  input  logic [1:0]              lsb_size,
  input  logic [ADDR_W-1:0]       lsb_addr,
  input  logic [31:0]             lsb_wdata,
  output logic                    lsb_done,
  output logic [31:0]             lsb_rdata,
  output logic [ADDR_W-1:0]       mem_a,
  output logic [7:0]              mem_dout,
  output logic                    mem_wr,
  input  logic [7:0]              mem_din
);

  import cpu_pkg::*;

  localparam int MAX_BYTES = (LINE_BYTES > 4) ? LINE_BYTES : 4;
  localparam int CNT_W     = $clog2(MAX_BYTES + 1);

  arb_state_t             state_r;
  arb_state_t             state_nx_s;
  logic                   last_ic_r;
  logic                   last_ic_nx_s;
  logic                   ic_ok_s;
  logic                   lsb_ok_s;
  logic                   start_s;
  logic [ADDR_W-1:0]      base_s;
  logic [CNT_W-1:0]       nbytes_s;
  logic                   run_s;
  logic                   wr_s;
  logic                   last_s;
  logic                   ic_fin_s;
  logic                   lsb_fin_s;
  logic                   lsb_rd_fin_s;
  logic [8*MAX_BYTES-1:0] cap_s;
  logic                   ic_done_r;
  logic                   lsb_done_r;
  logic [8*LINE_BYTES-1:0] ic_data_r;
  logic [31:0]            lsb_rdata_r;

  assign run_s     = (state_r != ARB_IDLE);
  assign wr_s      = (state_r == ARB_LSB_WR);
  assign ic_done   = ic_done_r;
  assign lsb_done  = lsb_done_r;
  assign ic_data   = ic_data_r;
  assign lsb_rdata = lsb_rdata_r;

  mem_byte_seq #(
    .MAX_BYTES (MAX_BYTES),
    .ADDR_W    (ADDR_W),
    .CNT_W     (CNT_W)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (start_s),
    .base     (base_s),
    .nbytes   (nbytes_s),
    .run      (run_s),
    .wr       (wr_s),
    .stall    (wr_stall),
    .wdata    (lsb_wdata),
    .mem_din  (mem_din),
    .mem_a    (mem_a),
    .mem_dout (mem_dout),
    .mem_wr   (mem_wr),
    .last     (last_s),
    .cap_data (cap_s)
  );

  // Arbitration and next-state; a requester whose done is showing is still holding req.
  always_comb begin
    ic_ok_s      = ic_req && !ic_done_r;
    lsb_ok_s     = lsb_req && !lsb_done_r;
    state_nx_s   = state_r;
    last_ic_nx_s = last_ic_r;
    start_s      = 1'b0;
    base_s       = '0;
    nbytes_s     = '0;
    case (state_r)
      ARB_IDLE: begin
        if (flush) begin
          state_nx_s = ARB_IDLE;
        end else if (ic_ok_s && (!lsb_ok_s || !last_ic_r)) begin
          state_nx_s   = ARB_IC_RD;
          last_ic_nx_s = 1'b1;
          start_s      = 1'b1;
          base_s       = ic_addr;
          nbytes_s     = CNT_W'(LINE_BYTES);
        end else if (lsb_ok_s) begin
          state_nx_s   = lsb_we ? ARB_LSB_WR : ARB_LSB_RD;
          last_ic_nx_s = 1'b0;
          start_s      = 1'b1;
          base_s       = lsb_addr;
          nbytes_s     = CNT_W'(size_to_bytes(lsb_size));
        end else begin
          state_nx_s = ARB_IDLE;
        end
      end
      ARB_IC_RD, ARB_LSB_RD: begin
        if (flush || last_s) begin
          state_nx_s = ARB_IDLE;
        end else begin
          state_nx_s = state_r;
        end
      end
      ARB_LSB_WR: begin
        // Stores are committed, so flush does not cut them short.
        if (last_s) begin
          state_nx_s = ARB_IDLE;
        end else begin
          state_nx_s = ARB_LSB_WR;
        end
      end
      default: state_nx_s = ARB_IDLE;
    endcase
    ic_fin_s     = (state_r == ARB_IC_RD) && last_s && !flush;
    lsb_rd_fin_s = (state_r == ARB_LSB_RD) && last_s && !flush;
    lsb_fin_s    = lsb_rd_fin_s || ((state_r == ARB_LSB_WR) && last_s);
  end

  // State and round-robin history.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= ARB_IDLE;
      last_ic_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      last_ic_r <= last_ic_nx_s;
    end
  end

  // Done pulses and returned data, loaded together with the final captured byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ic_done_r   <= 1'b0;
      lsb_done_r  <= 1'b0;
      ic_data_r   <= '0;
      lsb_rdata_r <= 32'h0000_0000;
    end else begin
      ic_done_r  <= ic_fin_s;
      lsb_done_r <= lsb_fin_s;
      if (ic_fin_s) begin
        ic_data_r <= cap_s[8*LINE_BYTES-1:0];
      end
      if (lsb_rd_fin_s) begin
        lsb_rdata_r <= cap_s[31:0];
      end
    end
  end

endmodule
